// File: rtl/sprite_blit_ctrl_if.sv
// Sprite blitter bus: draw request, sprite ROM ports and framebuffer write port.
// The controller uses the master modport; the host/ROM/framebuffer side uses the slave modport.
interface sprite_blit_ctrl_if;
  logic       start;
  logic       sprite_sel;
  logic [7:0] x_pos;
  logic [6:0] y_pos;
  logic       hflip;
  logic       busy;
  logic       done;
  logic [6:0] brick_addr;
  logic [2:0] brick_q;
  logic [7:0] mario_addr;
  logic [2:0] mario_q;
  logic [7:0] fb_x;
  logic [6:0] fb_y;
  logic [2:0] fb_color;
  logic       fb_wren;

  modport master (
    input  start, sprite_sel, x_pos, y_pos, hflip, brick_q, mario_q,
    output busy, done, brick_addr, mario_addr, fb_x, fb_y, fb_color, fb_wren
  );

  modport slave (
    output start, sprite_sel, x_pos, y_pos, hflip, brick_q, mario_q,
    input  busy, done, brick_addr, mario_addr, fb_x, fb_y, fb_color, fb_wren
  );
endinterface

// File: rtl/sprite_blit_ctrl.sv
// Copies a 16-wide sprite from ROM into the framebuffer with clipping and optional mirroring.
// Pixel r of the sweep appears on the fb port two cycles after its address; start is ignored while busy.
module sprite_blit_ctrl #(
  parameter int         SCREEN_W    = 160,
  parameter int         SCREEN_H    = 120,
  parameter logic [2:0] TRANSPARENT = 3'b000
) (
  input  logic                clock,
  input  logic                reset,
  sprite_blit_ctrl_if.master  bus
);

  localparam logic [8:0] SW = 9'(SCREEN_W);
  localparam logic [7:0] SH = 8'(SCREEN_H);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t     state, state_nxt;
  logic [7:0] idx;
  logic       drain_cnt;
  logic       sel_lat;
  logic       hflip_lat;
  logic [7:0] x_lat;
  logic [6:0] y_lat;
  logic [7:0] last_idx;
  logic       accept;
  logic       run_en;

  logic       p1_vld;
  logic [7:0] p1_idx;
  logic [2:0] q_sel;
  logic [3:0] col_eff;
  logic [8:0] scr_x;
  logic [7:0] scr_y;

  assign last_idx = sel_lat ? 8'd191 : 8'd127;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (idx == last_idx) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state != IDLE);
    bus.done = (state == DONE);
    run_en   = (state == RUN);
    accept   = (state == IDLE) && bus.start;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      idx       <= '0;
      drain_cnt <= 1'b0;
      sel_lat   <= 1'b0;
      hflip_lat <= 1'b0;
      x_lat     <= '0;
      y_lat     <= '0;
      p1_vld    <= 1'b0;
      p1_idx    <= '0;
    end else begin
      if (accept) begin
        sel_lat   <= bus.sprite_sel;
        hflip_lat <= bus.hflip;
        x_lat     <= bus.x_pos;
        y_lat     <= bus.y_pos;
        idx       <= '0;
      end else if (run_en) begin
        idx <= idx + 8'd1;
      end
      drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
      // p1 tracks the pixel whose ROM word arrives this cycle
      p1_vld    <= run_en;
      p1_idx    <= idx;
    end
  end

  assign bus.brick_addr = idx[6:0];
  assign bus.mario_addr = idx;

  // Wide sums so that off-screen pixels are clipped rather than wrapped
  always_comb begin
    q_sel   = sel_lat ? bus.mario_q : bus.brick_q;
    col_eff = hflip_lat ? (4'd15 - p1_idx[3:0]) : p1_idx[3:0];
    scr_x   = {1'b0, x_lat} + {5'b0, col_eff};
    scr_y   = {1'b0, y_lat} + {4'b0, p1_idx[7:4]};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bus.fb_wren  <= 1'b0;
      bus.fb_x     <= '0;
      bus.fb_y     <= '0;
      bus.fb_color <= '0;
    end else begin
      bus.fb_wren  <= p1_vld && (q_sel != TRANSPARENT) && (scr_x < SW) && (scr_y < SH);
      bus.fb_x     <= scr_x[7:0];
      bus.fb_y     <= scr_y[6:0];
      bus.fb_color <= q_sel;
    end
  end

endmodule
